mem_stage_sequencer: RTL and testbench
======================================

Name: mem_stage_sequencer

Overview:
Sequences all data-memory accesses issued by the MEM stage of the LC-3b pipeline onto the single-port data-cache handshake (read/write/resp).
- Single-access ops: LDR, LDB, STR, STB.
- Two-access indirect ops: LDI, STI, which read a pointer and then access it.
- Produces the pipeline-wide stall while a transaction is outstanding, and returns load data to writeback already aligned and extended.

Parameters:
WIDTH, 16, data/address width (lc3b_word)

Ports:
clk  in  1  system clock; one clock domain; all state updates on rising edge
reset  in  1  synchronous, active-high reset
valid_in  in  1  MEM-stage instruction valid
opcode  in  4  lc3b_opcode of MEM-stage instruction
read_memory  in  1  control-word read flag
write_memory  in  1  control-word write flag
addr_in  in  16  effective address from EX
wdata_in  in  16  store source register value
dmem_resp  in  1  cache completion pulse
dmem_rdata  in  16  cache read data, valid with dmem_resp
dmem_read  out  1  cache read request
dmem_write  out  1  cache write request
dmem_address  out  16  cache address
dmem_wdata  out  16  cache write data
dmem_wmask  out  2  byte-enable mask
stall  out  1  freeze all pipeline registers
done  out  1  one-cycle completion pulse
rdata_out  out  16  load result to WB mux, valid when done=1

Behaviour:
- States: IDLE, FIRST, SECOND, DONE.
- Reset values:
  - state=IDLE.
  - All outputs 0: dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_wmask, stall, done, rdata_out.
  - Latches addr_q, wdata_q, op_q, rdata_q are all 0.
- start = valid_in & (read_memory | write_memory), evaluated only in IDLE.
- Operation kind comes from opcode, not from the control flags. STI sets read_memory, not write_memory.
  - LDI/STI: indirect.
  - STR/STB: write.
  - All others: word read.
- IDLE:
  - On start, latch addr_in, wdata_in and opcode, then go to FIRST.
  - stall = start, combinational in the same cycle.
  - No dmem request is driven in IDLE.
- FIRST:
  - LDR/LDI/STI: dmem_read=1, address {addr_q[15:1],0}, wmask 2'b11.
  - LDB: dmem_read=1, address {addr_q[15:1],0}.
  - STR: dmem_write=1, wdata=wdata_q, mask 2'b11.
  - STB: dmem_write=1, wdata={wdata_q[7:0],wdata_q[7:0]}, mask 2'b01 if addr_q[0]=0, else 2'b10.
  - Requests are held steady until dmem_resp.
  - On dmem_resp:
    - Indirect op: addr_q <= dmem_rdata, go to SECOND.
    - Any other op: capture the load result into rdata_q, go to DONE.
- SECOND, at word address {addr_q[15:1],0}:
  - LDI: read.
  - STI: write wdata_q with mask 2'b11.
  - On dmem_resp, capture rdata_q (LDI), go to DONE.
- DONE:
  - stall=0, done=1, rdata_out=rdata_q, no request driven.
  - Next state is always IDLE. The pipeline advances on this edge, so the same instruction is never re-accepted.
- Load formatting:
  - LDB: rdata_out = SEXT of the selected byte (addr_q[0]=0 gives [7:0], 1 gives [15:8]).
  - LDR/LDI: full word.
  - Stores: rdata_out = 0.
- stall = 1 in FIRST and SECOND.
- dmem_resp outside FIRST/SECOND is ignored.
- Between accesses, request lines deassert for at least one cycle: the FIRST-to-SECOND transition drops the request for that edge only. dmem_read and dmem_write are never both 1.
- Reset mid-transaction: IDLE on the next edge. The request drops, latched state is cleared, and no done pulse is produced.
- Latency with a memory responding N cycles after the request:
  - Single-access op: done is 1 cycle after the FIRST resp.
  - Indirect op: two full handshakes, then done.

Decomposition:
- lc3b_types receives:
  - mem_seq_state_t enum (IDLE, FIRST, SECOND, DONE).
  - lc3b_mem_wmask typedef (2 bits).
- The existing lc3b_opcode/lc3b_word types are reused.
- One sub-module, mem_load_format: combinational byte select and sign extension, instantiated once on the rdata path.

Test Plan:
1. LDR, addr 0x1002, memory resp after 3 cycles with 0xBEEF -> dmem_read=1 at 0x1002 mask 11 for 3 cycles; stall=1 from the accept cycle; done=1 with rdata_out=0xBEEF the cycle after resp; then stall=0.
2. LDB, addr 0x2001, rdata 0x80FF -> address 0x2000; rdata_out=0xFF80. Repeat with addr 0x2000 -> rdata_out=0xFFFF.
3. STB, addr 0x3001, wdata 0x1234 -> dmem_write=1, address 0x3000, wdata 0x3434, wmask 10, dmem_read=0 throughout.
4. LDI, addr 0x4000:
   - First resp returns 0x5006 -> request drops for one cycle, then dmem_read at 0x5006.
   - Second resp 0x00AA -> done with rdata_out=0x00AA; stall continuous until done.
5. STI, addr 0x4000, wdata 0x7777, pointer 0x6000 -> read at 0x4000, then write 0x7777 at 0x6000 mask 11; never both request lines high.
6. reset asserted during the SECOND state of an LDI -> next cycle state=IDLE, requests 0, stall 0, no done pulse; a stray dmem_resp afterwards causes no state change.

Source files
------------

// File: rtl/mem_stage_sequencer_pkg.sv
// Shared LC-3b types used by the MEM-stage memory sequencer.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [3:0] {
        OP_BR   = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_LDB  = 4'b0010,
        OP_STB  = 4'b0011,
        OP_JSR  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_LDR  = 4'b0110,
        OP_STR  = 4'b0111,
        OP_RTI  = 4'b1000,
        OP_NOT  = 4'b1001,
        OP_LDI  = 4'b1010,
        OP_STI  = 4'b1011,
        OP_JMP  = 4'b1100,
        OP_SHF  = 4'b1101,
        OP_LEA  = 4'b1110,
        OP_TRAP = 4'b1111
    } lc3b_opcode;

    typedef logic [1:0] lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        SECOND,
        DONE
    } mem_seq_state_t;

    localparam lc3b_mem_wmask WMASK_WORD = 2'b11;
    localparam lc3b_mem_wmask WMASK_LO   = 2'b01;
    localparam lc3b_mem_wmask WMASK_HI   = 2'b10;

    // LDI/STI fetch a pointer first, then access the pointed-to word.
    function automatic logic is_indirect(lc3b_opcode op);
        return (op == OP_LDI) || (op == OP_STI);
    endfunction

    // Only STR/STB write on their first access; STI writes on its second.
    function automatic logic is_store(lc3b_opcode op);
        return (op == OP_STR) || (op == OP_STB);
    endfunction

endpackage

// File: rtl/mem_stage_sequencer_load_format.sv
// Load-data formatting: byte select with sign extension for LDB,
// full word for LDR/LDI, zero for everything else (stores).
module mem_load_format
    import lc3b_types::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  lc3b_opcode        opcode_i,
    input  logic              byte_sel_i,
    input  logic [WIDTH-1:0]  rdata_i,
    output logic [WIDTH-1:0]  data_o
);

    logic [7:0] byte_v;

    // Select the addressed byte and extend/pass according to opcode.
    always_comb begin
        byte_v = byte_sel_i ? rdata_i[15:8] : rdata_i[7:0];
        data_o = '0;
        case (opcode_i)
            OP_LDB:         data_o = {{(WIDTH-8){byte_v[7]}}, byte_v};
            OP_LDR, OP_LDI: data_o = rdata_i;
            default:        data_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage_sequencer.sv
// MEM-stage data-memory sequencer: maps LDR/LDB/STR/STB/LDI/STI onto the
// single-port cache handshake, stalls the pipeline while busy and returns
// formatted load data with a one-cycle done pulse.
module mem_stage_sequencer
    import lc3b_types::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [3:0]        opcode,
    input  logic              read_memory,
    input  logic              write_memory,
    input  logic [WIDTH-1:0]  addr_in,
    input  logic [WIDTH-1:0]  wdata_in,
    input  logic              dmem_resp,
    input  logic [WIDTH-1:0]  dmem_rdata,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [WIDTH-1:0]  dmem_address,
    output logic [WIDTH-1:0]  dmem_wdata,
    output logic [1:0]        dmem_wmask,
    output logic              stall,
    output logic              done,
    output logic [WIDTH-1:0]  rdata_out
);

    mem_seq_state_t    state_q, state_d;
    logic [WIDTH-1:0]  addr_q, addr_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;
    lc3b_opcode        op_q, op_d;
    logic [WIDTH-1:0]  rdata_q, rdata_d;
    // Set for the first SECOND cycle so the request drops between accesses.
    logic              gap_q, gap_d;

    logic              start;
    logic [WIDTH-1:0]  word_addr;
    logic [WIDTH-1:0]  fmt_data;

    assign start     = valid_in & (read_memory | write_memory);
    assign word_addr = {addr_q[WIDTH-1:1], 1'b0};

    mem_load_format #(
        .WIDTH (WIDTH)
    ) u_load_format (
        .opcode_i   (op_q),
        .byte_sel_i (addr_q[0]),
        .rdata_i    (dmem_rdata),
        .data_o     (fmt_data)
    );

    // State and transaction latches; synchronous reset clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            op_q    <= OP_BR;
            rdata_q <= '0;
            gap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_q    <= op_d;
            rdata_q <= rdata_d;
            gap_q   <= gap_d;
        end
    end

    // Next-state, latch updates and cache/pipeline outputs.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        op_d         = op_q;
        rdata_d      = rdata_q;
        gap_d        = 1'b0;
        dmem_read    = 1'b0;
        dmem_write   = 1'b0;
        dmem_address = '0;
        dmem_wdata   = '0;
        dmem_wmask   = '0;
        stall        = 1'b0;
        done         = 1'b0;
        rdata_out    = '0;

        case (state_q)
            IDLE: begin
                stall = start;
                if (start) begin
                    addr_d  = addr_in;
                    wdata_d = wdata_in;
                    op_d    = lc3b_opcode'(opcode);
                    state_d = FIRST;
                end
            end
            FIRST: begin
                stall        = 1'b1;
                dmem_address = word_addr;
                if (op_q == OP_STR) begin
                    dmem_write = 1'b1;
                    dmem_wdata = wdata_q;
                    dmem_wmask = WMASK_WORD;
                end else if (op_q == OP_STB) begin
                    dmem_write = 1'b1;
                    dmem_wdata = {wdata_q[7:0], wdata_q[7:0]};
                    dmem_wmask = addr_q[0] ? WMASK_HI : WMASK_LO;
                end else begin
                    dmem_read  = 1'b1;
                    dmem_wmask = WMASK_WORD;
                end
                if (dmem_resp) begin
                    if (is_indirect(op_q)) begin
                        addr_d  = dmem_rdata;
                        gap_d   = 1'b1;
                        state_d = SECOND;
                    end else begin
                        rdata_d = fmt_data;
                        state_d = DONE;
                    end
                end
            end
            SECOND: begin
                stall = 1'b1;
                if (!gap_q) begin
                    dmem_address = word_addr;
                    dmem_wmask   = WMASK_WORD;
                    if (op_q == OP_STI) begin
                        dmem_write = 1'b1;
                        dmem_wdata = wdata_q;
                    end else begin
                        dmem_read = 1'b1;
                    end
                    if (dmem_resp) begin
                        rdata_d = fmt_data;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done      = 1'b1;
                rdata_out = rdata_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_stage_sequencer.sv
// Randomized bench for mem_stage_sequencer with a memory responder and a
// transaction-level reference model of the expected access sequence.
module tb_mem_stage_sequencer;

    localparam logic [3:0] T_ADD = 4'h1;
    localparam logic [3:0] T_LDB = 4'h2;
    localparam logic [3:0] T_STB = 4'h3;
    localparam logic [3:0] T_LDR = 4'h6;
    localparam logic [3:0] T_STR = 4'h7;
    localparam logic [3:0] T_LDI = 4'hA;
    localparam logic [3:0] T_STI = 4'hB;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [3:0]  opcode;
    logic        read_memory;
    logic        write_memory;
    logic [15:0] addr_in;
    logic [15:0] wdata_in;
    logic        dmem_resp;
    logic [15:0] dmem_rdata;
    logic        dmem_read;
    logic        dmem_write;
    logic [15:0] dmem_address;
    logic [15:0] dmem_wdata;
    logic [1:0]  dmem_wmask;
    logic        stall;
    logic        done;
    logic [15:0] rdata_out;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  mask;
        logic        mask_care;
    } acc_t;

    acc_t        exp_q[$];
    logic [15:0] phys_mem [logic [15:0]];
    logic [15:0] ref_mem  [logic [15:0]];

    always #5 clk = ~clk;

    mem_stage_sequencer #(
        .WIDTH (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_in     (valid_in),
        .opcode       (opcode),
        .read_memory  (read_memory),
        .write_memory (write_memory),
        .addr_in      (addr_in),
        .wdata_in     (wdata_in),
        .dmem_resp    (dmem_resp),
        .dmem_rdata   (dmem_rdata),
        .dmem_read    (dmem_read),
        .dmem_write   (dmem_write),
        .dmem_address (dmem_address),
        .dmem_wdata   (dmem_wdata),
        .dmem_wmask   (dmem_wmask),
        .stall        (stall),
        .done         (done),
        .rdata_out    (rdata_out)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return 16'(a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] phys_rd(input logic [15:0] a);
        return phys_mem.exists(a) ? phys_mem[a] : init_val(a);
    endfunction

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    task automatic preset(input logic [15:0] a, input logic [15:0] v);
        phys_mem[a] = v;
        ref_mem[a]  = v;
    endtask

    function automatic acc_t mk_acc(input logic we, input logic [15:0] a, input logic [15:0] wd,
                                    input logic [1:0] m, input logic mc);
        acc_t r;
        r.we = we; r.addr = a; r.wdata = wd; r.mask = m; r.mask_care = mc;
        return r;
    endfunction

    task automatic idle_cycle();
        @(negedge clk);
        valid_in = 1'($urandom); opcode = T_ADD; read_memory = 1'b0; write_memory = 1'b0;
        #1;
        check_val("idle_stall", 32'(stall), 0);
        @(negedge clk);
        check_val("idle_req", 32'({dmem_read, dmem_write, done}), 0);
        valid_in = 1'b0;
    endtask

    task automatic run_txn(input logic [3:0] op, input logic [15:0] addr, input logic [15:0] wd,
                           input int unsigned lat1, input int unsigned lat2, input bit abort2);
        logic [15:0] wa, pa, w, exp_rd;
        logic [7:0]  b;
        int unsigned idx, held, gap, lat;
        int          after_resp;
        bit          got_done, req;
        acc_t        e;

        // Reference model: expected accesses and result, from the ISA rules.
        wa = {addr[15:1], 1'b0};
        exp_rd = '0;
        exp_q.delete();
        case (op)
            T_LDR: begin
                exp_q.push_back(mk_acc(1'b0, wa, '0, 2'b11, 1'b1));
                exp_rd = ref_rd(wa);
            end
            T_LDB: begin
                exp_q.push_back(mk_acc(1'b0, wa, '0, 2'b11, 1'b0));
                w = ref_rd(wa);
                b = addr[0] ? w[15:8] : w[7:0];
                exp_rd = {{8{b[7]}}, b};
            end
            T_STR: begin
                exp_q.push_back(mk_acc(1'b1, wa, wd, 2'b11, 1'b1));
                ref_mem[wa] = wd;
            end
            T_STB: begin
                exp_q.push_back(mk_acc(1'b1, wa, {wd[7:0], wd[7:0]}, addr[0] ? 2'b10 : 2'b01, 1'b1));
                w = ref_rd(wa);
                if (addr[0]) w[15:8] = wd[7:0]; else w[7:0] = wd[7:0];
                ref_mem[wa] = w;
            end
            T_LDI: begin
                w  = ref_rd(wa);
                pa = {w[15:1], 1'b0};
                exp_q.push_back(mk_acc(1'b0, wa, '0, 2'b11, 1'b1));
                exp_q.push_back(mk_acc(1'b0, pa, '0, 2'b11, 1'b1));
                exp_rd = ref_rd(pa);
            end
            default: begin
                w  = ref_rd(wa);
                pa = {w[15:1], 1'b0};
                exp_q.push_back(mk_acc(1'b0, wa, '0, 2'b11, 1'b1));
                exp_q.push_back(mk_acc(1'b1, pa, wd, 2'b11, 1'b1));
                ref_mem[pa] = wd;
            end
        endcase

        @(negedge clk);
        valid_in     = 1'b1;
        opcode       = op;
        write_memory = (op == T_STR) || (op == T_STB);
        read_memory  = !write_memory;
        addr_in      = addr;
        wdata_in     = wd;
        #1;
        check_val("stall_accept", 32'(stall), 1);
        check_val("no_req_accept", 32'({dmem_read, dmem_write}), 0);

        idx = 0; held = 0; gap = 0; after_resp = -1; got_done = 1'b0;
        for (int cyc = 0; cyc < 200 && !got_done; cyc++) begin
            @(negedge clk);
            dmem_resp  = 1'b0;
            dmem_rdata = 16'($urandom);
            if (after_resp >= 0) after_resp++;
            check_val("rw_excl", 32'(dmem_read & dmem_write), 0);
            if (done) begin
                check_val("rdata_out", 32'(rdata_out), 32'(exp_rd));
                check_val("stall_done", 32'(stall), 0);
                check_val("access_count", idx, exp_q.size());
                check_val("done_latency", 32'(after_resp), 1);
                valid_in = 1'b0; read_memory = 1'b0; write_memory = 1'b0;
                got_done = 1'b1;
            end else begin
                check_val("stall_busy", 32'(stall), 1);
                req = dmem_read | dmem_write;
                if (req) begin
                    if (idx >= exp_q.size()) begin
                        check_val("extra_access", idx, exp_q.size());
                        break;
                    end
                    e = exp_q[idx];
                    if (held == 0 && idx > 0) check_val("gap_len", gap, 1);
                    check_val("req_write", 32'(dmem_write), 32'(e.we));
                    check_val("req_addr", 32'(dmem_address), 32'(e.addr));
                    if (e.we) check_val("req_wdata", 32'(dmem_wdata), 32'(e.wdata));
                    if (e.mask_care) check_val("req_mask", 32'(dmem_wmask), 32'(e.mask));
                    if (abort2 && idx == 1) begin
                        reset = 1'b1;
                        valid_in = 1'b0; read_memory = 1'b0; write_memory = 1'b0;
                        @(negedge clk);
                        reset = 1'b0;
                        check_val("abort_req", 32'({dmem_read, dmem_write}), 0);
                        check_val("abort_stall", 32'(stall), 0);
                        check_val("abort_done", 32'(done), 0);
                        dmem_resp  = 1'b1;
                        dmem_rdata = 16'h1234;
                        @(negedge clk);
                        dmem_resp = 1'b0;
                        check_val("stray_req", 32'({dmem_read, dmem_write}), 0);
                        check_val("stray_stall_done", 32'({stall, done}), 0);
                        @(negedge clk);
                        check_val("stray_idle", 32'({dmem_read, dmem_write, stall, done}), 0);
                        return;
                    end
                    held++;
                    lat = (idx == 0) ? lat1 : lat2;
                    if (held >= lat) begin
                        if (dmem_write) begin
                            w = phys_rd(dmem_address);
                            if (dmem_wmask[0]) w[7:0]  = dmem_wdata[7:0];
                            if (dmem_wmask[1]) w[15:8] = dmem_wdata[15:8];
                            phys_mem[dmem_address] = w;
                        end else begin
                            dmem_rdata = phys_rd(dmem_address);
                        end
                        dmem_resp = 1'b1;
                        idx++; held = 0; gap = 0; after_resp = 0;
                    end
                end else if (idx == 0) begin
                    check_val("req_first_cycle", 32'(req), 1);
                end else begin
                    gap++;
                end
            end
        end
        if (!got_done) check_val("timeout_done", 32'(got_done), 1);
        @(negedge clk);
        dmem_resp = 1'b0;
        check_val("idle_after_stall", 32'(stall), 0);
        check_val("idle_after_req", 32'({dmem_read, dmem_write, done}), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [3:0] ops [6];
        ops[0] = T_LDR; ops[1] = T_LDB; ops[2] = T_STR;
        ops[3] = T_STB; ops[4] = T_LDI; ops[5] = T_STI;

        reset = 1'b1; valid_in = 1'b0; opcode = '0; read_memory = 1'b0; write_memory = 1'b0;
        addr_in = '0; wdata_in = '0; dmem_resp = 1'b0; dmem_rdata = '0;
        repeat (2) @(negedge clk);
        check_val("rst_req", 32'({dmem_read, dmem_write}), 0);
        check_val("rst_addr", 32'(dmem_address), 0);
        check_val("rst_wdata", 32'(dmem_wdata), 0);
        check_val("rst_wmask", 32'(dmem_wmask), 0);
        check_val("rst_stall_done", 32'({stall, done}), 0);
        check_val("rst_rdata", 32'(rdata_out), 0);
        reset = 1'b0;

        idle_cycle();

        preset(16'h1002, 16'hBEEF);
        run_txn(T_LDR, 16'h1002, 16'h0000, 3, 1, 1'b0);
        preset(16'h2000, 16'h80FF);
        run_txn(T_LDB, 16'h2001, 16'h0000, 2, 1, 1'b0);
        run_txn(T_LDB, 16'h2000, 16'h0000, 1, 1, 1'b0);
        run_txn(T_STB, 16'h3001, 16'h1234, 2, 1, 1'b0);
        preset(16'h4000, 16'h5006);
        preset(16'h5006, 16'h00AA);
        run_txn(T_LDI, 16'h4000, 16'h0000, 2, 3, 1'b0);
        preset(16'h4000, 16'h6000);
        run_txn(T_STI, 16'h4000, 16'h7777, 1, 2, 1'b0);
        run_txn(T_LDI, 16'h4000, 16'h0000, 1, 1, 1'b0);
        run_txn(T_LDI, 16'h4000, 16'h0000, 2, 3, 1'b1);

        for (int i = 0; i < 60; i++) begin
            run_txn(ops[$urandom_range(0, 5)], 16'h4000 | 16'($urandom_range(0, 15)),
                    16'($urandom), $urandom_range(1, 4), $urandom_range(1, 4), 1'b0);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        // Read back the whole pool so any corrupted store shows up.
        for (int a = 0; a < 16; a += 2) begin
            run_txn(T_LDR, 16'h4000 | 16'(a), 16'h0000, 1, 1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
